majority_voter_pipe: RTL and testbench

Parametrised, pipelined N-way bitwise majority voter for W-bit words. It accepts N redundant copies of a word over a valid/ready handshake and emits the voted word. With each result it reports which channels disagreed and whether the vote was unanimous. It keeps a saturating per-channel fault counter and sits between replicated datapaths (TMR/NMR) and downstream single-copy logic.

---
 rtl/majority_voter_pipe.sv | 125 ++++++++++++
 tb/tb_majority_voter_pipe.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/majority_voter_pipe.sv
// majority_voter_pipe
//   Two-stage pipelined N-way bitwise majority voter for W-bit words, with
//   per-channel saturating fault counters.
//
// Ports
//   clk            sole clock, rising edge
//   rst_n          asynchronous active-low reset
//   in_valid       in_data carries N redundant words
//   in_ready       block can accept a set of words this cycle
//   in_data        channel i at [i*W +: W]
//   out_valid      out_data / fault_mask / out_unanimous are valid
//   out_ready      consumer accepts the output
//   out_data       voted word
//   fault_mask     bit i set when channel i disagrees with out_data
//   out_unanimous  set when no channel disagrees
//   clr_cnt        synchronous clear of all fault counters
//   fault_cnt      channel i counter at [i*CNT_W +: CNT_W]
module majority_voter_pipe #(
    parameter int N     = 3,
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*W-1:0]     in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_data,
    output logic [N-1:0]       fault_mask,
    output logic               out_unanimous,
    input  logic               clr_cnt,
    output logic [N*CNT_W-1:0] fault_cnt
);

    if ((N < 3) || ((N % 2) == 0)) begin : g_bad_n
        $error("majority_voter_pipe: N must be odd and at least 3");
    end

    localparam int              CW      = $clog2(N + 1);
    localparam logic [CW-1:0]   THRESH  = CW'((N + 1) / 2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic           s1_valid;
    logic [N*W-1:0] s1_data;
    logic           s2_load;
    logic           in_fire;
    logic           out_fire;
    logic [W-1:0]   vote;
    logic [N-1:0]   mask;
    logic [CW-1:0]  ones;

    // S2 refills whenever it is empty or being drained this cycle, so
    // in_ready depends on out_ready but never on in_valid.
    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        vote = '0;
        ones = '0;
        for (int b = 0; b < W; b++) begin
            ones = '0;
            for (int i = 0; i < N; i++) begin
                ones = ones + CW'(s1_data[i*W + b]);
            end
            vote[b] = (ones >= THRESH);
        end
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (s1_data[i*W +: W] != vote);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_data  <= in_data;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            fault_mask    <= '0;
            out_unanimous <= 1'b0;
        end else if (s2_load) begin
            out_valid     <= 1'b1;
            out_data      <= vote;
            fault_mask    <= mask;
            out_unanimous <= ~|mask;
        end else if (out_fire) begin
            out_valid     <= 1'b0;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;

        // Clear wins over a same-cycle increment; counters stick at max.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (clr_cnt) begin
                cnt_q <= '0;
            end else if (out_fire && fault_mask[i] && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end

        assign fault_cnt[i*CNT_W +: CNT_W] = cnt_q;
    end

endmodule

// File: tb/tb_majority_voter_pipe.sv
// Directed testbench for majority_voter_pipe. Two instances: N=3/W=8 with
// 2-bit counters (saturation reachable quickly) and N=5/W=8/CNT_W=8.
module tb_majority_voter_pipe;

    logic        clk;
    logic        rst_n;

    logic        in_valid3, in_ready3, out_valid3, out_ready3, out_unan3, clr3;
    logic [23:0] in_data3;
    logic [7:0]  out_data3;
    logic [2:0]  fault_mask3;
    logic [5:0]  fault_cnt3;

    logic        in_valid5, in_ready5, out_valid5, out_ready5, out_unan5, clr5;
    logic [39:0] in_data5;
    logic [7:0]  out_data5;
    logic [4:0]  fault_mask5;
    logic [39:0] fault_cnt5;

    int checks   = 0;
    int failures = 0;

    majority_voter_pipe #(.N(3), .W(8), .CNT_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .fault_mask(fault_mask3), .out_unanimous(out_unan3),
        .clr_cnt(clr3), .fault_cnt(fault_cnt3)
    );

    majority_voter_pipe #(.N(5), .W(8), .CNT_W(8)) dut5 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
        .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5),
        .fault_mask(fault_mask5), .out_unanimous(out_unan5),
        .clr_cnt(clr5), .fault_cnt(fault_cnt5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the dut3 pipe empty; returns at the negedge
    // where the result is visible and about to be taken (out_ready = 1).
    task automatic xfer3(input logic [23:0] d);
        in_data3   = d;
        in_valid3  = 1'b1;
        out_ready3 = 1'b1;
        @(negedge clk);
        in_valid3 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int next_word;
        int exp_word;
        int occ;
        bit in_fire;
        bit out_fire;

        rst_n      = 1'b0;
        in_valid3  = 1'b1;
        in_data3   = {8'h0F, 8'hF0, 8'hF0};
        out_ready3 = 1'b1;
        clr3       = 1'b0;
        in_valid5  = 1'b0;
        in_data5   = '0;
        out_ready5 = 1'b1;
        clr5       = 1'b0;

        // Reset held for 3 cycles with in_valid asserted
        repeat (3) begin
            @(negedge clk);
            check("rst_out_valid", out_valid3, 1'b0);
            check("rst_fault_cnt", fault_cnt3, 6'h00);
        end
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready3, 1'b1);
        @(negedge clk);
        in_valid3 = 1'b0;
        check("latency_not_early", out_valid3, 1'b0);
        @(negedge clk);
        check("latency_out_valid", out_valid3, 1'b1);
        check("single_fault_data", out_data3, 8'hF0);
        check("single_fault_mask", fault_mask3, 3'b100);
        check("single_fault_unan", out_unan3, 1'b0);
        @(negedge clk);
        check("single_fault_cnt", fault_cnt3, {2'd1, 2'd0, 2'd0});
        check("single_fault_drained", out_valid3, 1'b0);

        // Bitwise mix, N=3
        xfer3({8'hF0, 8'hCC, 8'hAA});
        check("mix3_data", out_data3, 8'hE8);
        check("mix3_mask", fault_mask3, 3'b111);
        check("mix3_unan", out_unan3, 1'b0);
        @(negedge clk);
        check("mix3_cnt", fault_cnt3, {2'd2, 2'd1, 2'd1});

        // Unanimous word leaves counters alone
        xfer3({8'h5A, 8'h5A, 8'h5A});
        check("unan_data", out_data3, 8'h5A);
        check("unan_mask", fault_mask3, 3'b000);
        check("unan_flag", out_unan3, 1'b1);
        @(negedge clk);
        check("unan_cnt", fault_cnt3, {2'd2, 2'd1, 2'd1});

        // Bitwise mix, N=5
        in_data5  = {8'h0F, 8'h00, 8'h00, 8'hFF, 8'hFF};
        in_valid5 = 1'b1;
        @(negedge clk);
        in_valid5 = 1'b0;
        @(negedge clk);
        check("mix5_valid", out_valid5, 1'b1);
        check("mix5_data", out_data5, 8'h0F);
        check("mix5_mask", fault_mask5, 5'b01111);
        check("mix5_unan", out_unan5, 1'b0);
        @(negedge clk);
        check("mix5_cnt", fault_cnt5, 40'h00_01_01_01_01);

        // Backpressure: words 1..6, out_ready low for cycles 3..7
        next_word = 1;
        exp_word  = 1;
        occ       = 0;
        for (int cyc = 0; cyc < 30 && exp_word <= 6; cyc++) begin
            out_ready3 = !(cyc >= 3 && cyc <= 7);
            in_valid3  = (next_word <= 6);
            in_data3   = {3{next_word[7:0]}};
            #1;
            check("bp_in_ready", in_ready3, !(occ == 2 && !out_ready3));
            if (out_valid3) begin
                check("bp_out_data", out_data3, exp_word[7:0]);
                check("bp_out_mask", fault_mask3, 3'b000);
            end
            in_fire  = in_valid3 && in_ready3;
            out_fire = out_valid3 && out_ready3;
            if (in_fire)  next_word++;
            if (out_fire) exp_word++;
            occ = occ + int'(in_fire) - int'(out_fire);
            @(negedge clk);
        end
        check("bp_all_delivered", exp_word, 7);
        in_valid3  = 1'b0;
        out_ready3 = 1'b1;
        @(negedge clk);
        check("bp_drained", out_valid3, 1'b0);

        // Counter clear, then saturation with CNT_W = 2
        clr3 = 1'b1;
        @(negedge clk);
        clr3 = 1'b0;
        check("clr_cnt_zero", fault_cnt3, 6'h00);
        for (int k = 1; k <= 5; k++) begin
            xfer3({8'h11, 8'h11, 8'h22});
            check("sat_mask", fault_mask3, 3'b001);
            @(negedge clk);
            check("sat_cnt", fault_cnt3, {2'd0, 2'd0, (k >= 3) ? 2'd3 : 2'(k)});
        end

        // clr_cnt together with a faulty output transfer
        xfer3({8'h11, 8'h11, 8'h22});
        clr3 = 1'b1;
        @(negedge clk);
        clr3 = 1'b0;
        check("clr_vs_inc_cnt", fault_cnt3, 6'h00);
        check("clr_vs_inc_drain", out_valid3, 1'b0);

        // Async reset mid-stream with two words buffered
        xfer3({8'h11, 8'h11, 8'h22});
        @(negedge clk);
        check("pre_reset_cnt", fault_cnt3, 6'h01);
        out_ready3 = 1'b0;
        in_valid3  = 1'b1;
        in_data3   = {3{8'hA1}};
        @(negedge clk);
        in_data3   = {3{8'hA2}};
        @(negedge clk);
        in_valid3  = 1'b0;
        check("buffered_full", in_ready3, 1'b0);
        check("buffered_head", out_data3, 8'hA1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid3, 1'b0);
        check("async_rst_cnt3", fault_cnt3, 6'h00);
        check("async_rst_cnt5", fault_cnt5, 40'h0);
        @(negedge clk);
        rst_n      = 1'b1;
        out_ready3 = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("no_stale_word", out_valid3, 1'b0);
        end
        xfer3({8'h3C, 8'h3C, 8'h3C});
        check("post_rst_data", out_data3, 8'h3C);
        check("post_rst_unan", out_unan3, 1'b1);
        @(negedge clk);
        check("post_rst_empty", out_valid3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
